// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with stall/bubble/flush handling, a one-entry skid buffer
// that absorbs an item arriving while the source stage is stopped, and a stall-cycle counter.
module pipe_stage_skid_reg #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int STALL_W = 6,
   parameter int STAGE   = 1,
   parameter int CNT_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   input  logic [ADDR_W-1:0]  in_pc_i,
   input  logic [DATA_W-1:0]  in_data_i,
   output logic               out_valid_o,
   output logic [ADDR_W-1:0]  out_pc_o,
   output logic [DATA_W-1:0]  out_data_o,
   output logic               skid_full_o,
   output logic               overflow_o,
   output logic [CNT_W-1:0]   stall_cnt_o
);

   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_pc_q,    out_pc_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              skid_full_q, skid_full_d;
   logic [ADDR_W-1:0] skid_pc_q,   skid_pc_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              overflow_q,  overflow_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic src_stall;
   logic dst_stall;

   assign src_stall = stall_i[STAGE];
   assign dst_stall = stall_i[STAGE+1];

   // Only two bits of the core stall vector matter to this stage.
   logic unused_stall;
   assign unused_stall = ^stall_i;

   always_comb begin
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_data_d  = out_data_q;
      skid_full_d = skid_full_q;
      skid_pc_d   = skid_pc_q;
      skid_data_d = skid_data_q;
      overflow_d  = overflow_q;
      stall_cnt_d = '0;

      if (src_stall) begin
         if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end

      if (flush_i) begin
         out_valid_d = 1'b0;
         out_pc_d    = '0;
         out_data_d  = '0;
         skid_full_d = 1'b0;
         skid_pc_d   = '0;
         skid_data_d = '0;
      end else if (!src_stall) begin
         if (skid_full_q) begin
            // Skid entry is older than the input, so it leaves first.
            out_valid_d = 1'b1;
            out_pc_d    = skid_pc_q;
            out_data_d  = skid_data_q;
            if (in_valid_i) begin
               skid_pc_d   = in_pc_i;
               skid_data_d = in_data_i;
            end else begin
               skid_full_d = 1'b0;
            end
         end else begin
            out_valid_d = in_valid_i;
            out_pc_d    = in_valid_i ? in_pc_i   : '0;
            out_data_d  = in_valid_i ? in_data_i : '0;
         end
      end else begin
         if (!dst_stall) begin
            out_valid_d = 1'b0;
            out_pc_d    = '0;
            out_data_d  = '0;
         end
         if (in_valid_i) begin
            if (!skid_full_q) begin
               skid_full_d = 1'b1;
               skid_pc_d   = in_pc_i;
               skid_data_d = in_data_i;
            end else begin
               overflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_data_q  <= '0;
         skid_full_q <= 1'b0;
         skid_pc_q   <= '0;
         skid_data_q <= '0;
         overflow_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_data_q  <= out_data_d;
         skid_full_q <= skid_full_d;
         skid_pc_q   <= skid_pc_d;
         skid_data_q <= skid_data_d;
         overflow_q  <= overflow_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_pc_o    = out_pc_q;
   assign out_data_o  = out_data_q;
   assign skid_full_o = skid_full_q;
   assign overflow_o  = overflow_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
